// File: rtl/lb_pkg.sv
// Shared types and widths for the local register bus initiator.
package lb_pkg;

  localparam int unsigned LB_ADDR_W = 8;
  localparam int unsigned LB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT,
    RESP
  } lb_state_e;

  typedef struct packed {
    logic                 write;
    logic [LB_ADDR_W-1:0] addr;
    logic [LB_DATA_W-1:0] wdata;
  } lb_cmd_t;

endpackage

// File: rtl/lb_cmd_fifo.sv
// Small command FIFO: power-of-2 depth, registered storage, occupancy counter.
module lb_cmd_fifo import lb_pkg::*; #(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  lb_cmd_t wdata_i,
  input  logic    pop_i,
  output lb_cmd_t rdata_o,
  output logic    full_o,
  output logic    empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;
  lb_cmd_t       mem_q [DEPTH];

  assign full_o  = (count_q == DEPTH[AW:0]);
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A push while full is accepted when a pop frees the slot in the same cycle.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign rdata_o = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/lb_master.sv
// Local register bus initiator: queues commands, runs one strobe/ack transaction
// at a time and returns read data or a timeout flag on a valid/ready port.
module lb_master import lb_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned ACK_EN     = 1,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [LB_ADDR_W-1:0] cmd_addr,
  input  logic [LB_DATA_W-1:0] cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_write,
  output logic [LB_ADDR_W-1:0] rsp_addr,
  output logic [LB_DATA_W-1:0] rsp_rdata,
  output logic                 rsp_timeout,
  output logic [LB_ADDR_W-1:0] Address,
  output logic [LB_DATA_W-1:0] DataIn,
  output logic                 Read,
  output logic                 Write,
  input  logic [LB_DATA_W-1:0] DataOut,
  input  logic                 ack
);

  lb_state_e            state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [LB_ADDR_W-1:0] addr_q, addr_d;
  logic [LB_DATA_W-1:0] data_q, data_d;
  logic                 write_q, write_d;
  logic [LB_DATA_W-1:0] rdata_q, rdata_d;
  logic                 tout_q, tout_d;

  logic    fifo_pop, fifo_full, fifo_empty;
  lb_cmd_t fifo_cmd, push_cmd;

  assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  lb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_valid && cmd_ready),
    .wdata_i (push_cmd),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_cmd),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    write_d  = write_q;
    rdata_d  = rdata_q;
    tout_d   = tout_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = fifo_cmd.addr;
          data_d   = fifo_cmd.wdata;
          write_d  = fifo_cmd.write;
          rdata_d  = '0;
          tout_d   = 1'b0;
          state_d  = STROBE;
        end
      end
      STROBE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (ACK_EN != 0) begin
          // ack takes priority over the final timeout cycle
          if (ack) begin
            rdata_d = write_q ? '0 : DataOut;
            state_d = RESP;
          end else if (cnt_q + 8'd1 == TIMEOUT[7:0]) begin
            tout_d  = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          if (write_q) begin
            state_d = RESP;
          end else if (cnt_q + 8'd1 == RD_LAT[7:0]) begin
            rdata_d = DataOut;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      tout_q  <= tout_d;
    end
  end

  assign cmd_ready   = !fifo_full;
  assign Address     = addr_q;
  assign DataIn      = data_q;
  assign Read        = (state_q == STROBE) && !write_q;
  assign Write       = (state_q == STROBE) && write_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_write   = write_q;
  assign rsp_addr    = addr_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_timeout = tout_q;

endmodule

// File: doc/lb_master.md
Name: lb_master

Overview:
- Initiator for the local register bus (Address / DataIn / Read / Write out; OR-combined DataOut / ack back) that the per-channel TDC register banks respond to.
- Accepts read/write commands from an upstream controller (slow-control/readout path), buffers them in a 2-deep FIFO, and issues one bus transaction at a time.
- Returns read data, or a timeout flag, on a valid/ready response port.
- Sits between the slow-control command decoder and the OR-tree of register DataOut buses.

Parameters:
- FIFO_DEPTH, 2, command FIFO entries (power of 2, min 2).
- ACK_EN, 1, 1 = complete on bus ack; 0 = complete after RD_LAT cycles and ignore ack.
- RD_LAT, 1, cycles from Read strobe to sampling DataOut when ACK_EN=0 (1..15).
- TIMEOUT, 15, max cycles waiting for ack after the strobe (1..255).

Ports:
- clk  in  1  bus clock (50 MHz domain).
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  8  register address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  echo of the command type.
- rsp_addr  out  8  echo of the address.
- rsp_rdata  out  32  read data (0 for writes and on timeout).
- rsp_timeout  out  1  no ack within TIMEOUT.
- Address  out  8  bus address.
- DataIn  out  32  bus write data (slave input).
- Read  out  1  one-cycle read strobe.
- Write  out  1  one-cycle write strobe.
- DataOut  in  32  OR-combined slave read data.
- ack  in  1  OR-combined slave ack.

Behaviour:
- Reset (async, immediate): all outputs 0, cmd_ready = 1. FIFO emptied, FSM in IDLE, counters cleared. The FIFO is emptied on reset, so commands in flight are lost and no response is produced for them.
- FIFO:
  - Push on cmd_valid & cmd_ready. Pop when IDLE takes an entry.
  - cmd_ready = !full.
  - Push and pop in the same cycle while full is allowed, and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, STROBE, WAIT, RESP.
- IDLE:
  - If the FIFO is not empty: pop, register addr/data/type into Address/DataIn, go to STROBE.
  - Address and DataIn hold their value until the next command is loaded.
- STROBE: exactly one cycle with Read or Write = 1, never both. Clear wait_cnt, go to WAIT.
- WAIT, ACK_EN=1:
  - Each cycle, if ack = 1, capture DataOut (reads only) and go to RESP.
  - Otherwise increment wait_cnt. When wait_cnt reaches TIMEOUT, set timeout, rdata = 0, go to RESP.
  - An ack arriving in the same cycle the count reaches TIMEOUT counts as success.
  - An ack seen during the STROBE cycle is ignored.
- WAIT, ACK_EN=0:
  - Reads: capture DataOut after RD_LAT cycles in WAIT; timeout never set.
  - Writes: go to RESP after 1 cycle.
- RESP:
  - rsp_valid = 1 with all rsp_* fields stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE in the next cycle.
  - Back-pressure stalls the FSM; the FIFO keeps accepting until full.
- Latency, read with ack in the first WAIT cycle: push at cycle 0, IDLE pop at cycle 1, Read at cycle 2, ack at cycle 3, rsp_valid at cycle 4.
- Throughput: at most one transaction per 4 cycles.
- rsp_rdata is 0 for writes.
- Unacked writes are reported with rsp_timeout = 1 (ACK_EN=1).

Decomposition:
- Package lb_pkg: FSM state enum (IDLE, STROBE, WAIT, RESP), LB_ADDR_W = 8, LB_DATA_W = 32, command struct {write, addr, wdata}.
- One sub-module: lb_cmd_fifo. Parameterised depth, synchronous write/read, async reset, full/empty flags.

Test Plan:
- Write 0x0F000000 to addr 0x03; slave acks 1 cycle after the strobe -> Write pulse exactly 1 cycle with Address = 0x03, DataIn = 0x0F000000; response write = 1, timeout = 0, rdata = 0.
- Read addr 0x01; slave returns 0xFFFFFFFF with ack -> rsp_rdata = 0xFFFFFFFF; rsp_valid 4 cycles after the push.
- Read unmapped addr 0xFC (no ack), TIMEOUT = 15 -> rsp_timeout = 1, rdata = 0, rsp_valid 15 cycles after the strobe cycle + 1.
- Push 3 commands back-to-back with rsp_ready = 0 -> cmd_ready drops after the FIFO fills. Responses come out in order once rsp_ready = 1, with no command lost or duplicated.
- ACK_EN = 0, RD_LAT = 2, read addr 0x00 with DataOut = 0x00000007 -> sampled 2 cycles after the strobe; ack is ignored.
- Assert rst during WAIT -> all outputs 0 immediately (async), FIFO empty, and no response for the aborted command after release.
